mul_share_arbiter: RTL and testbench

Round-robin scheduler that time-shares one combinational 32x32 signed Booth multiplier among N_REQ requesters on the slow_clk domain. Accepts one operand pair at a time via valid/ready, drives the multiplier's operand registers, and waits a fixed settle window. It then captures the 64-bit product and returns it on a single response channel tagged with the requester index. Sits between client blocks and the shared multiplier instance.

---
 rtl/mul_share_arbiter.sv | 105 ++++++++++
 tb/tb_mul_share_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one combinational 32x32 signed
// multiplier among N_REQ requesters. It accepts one operand pair, lets the
// multiplier settle for WAIT_CYCLES, and returns the product tagged with the
// owning requester index.
module mul_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  slow_clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [63:0]           mul_p,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_p,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   cur_id;
  logic [7:0]        cnt;

  logic              gnt_found;
  logic [N_REQ-1:0]  gnt_oh;
  logic [ID_W-1:0]   gnt_idx;
  logic [31:0]       gnt_a;
  logic [31:0]       gnt_b;

  // Round-robin pick: first pass scans indices above last_grant, second pass
  // wraps to the indices at or below it, so the search starts at last_grant+1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_a     = '0;
    gnt_b     = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!gnt_found && req_valid[i] &&
            ((pass == 0) ? (i > int'(last_grant)) : (i <= int'(last_grant)))) begin
          gnt_found = 1'b1;
          gnt_oh[i] = 1'b1;
          gnt_idx   = ID_W'(i);
          gnt_a     = req_a[32*i +: 32];
          gnt_b     = req_b[32*i +: 32];
        end
      end
    end
  end

  // Grant is only offered while idle; it never depends on rsp_ready.
  assign req_ready = (state == IDLE) ? gnt_oh : '0;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  // Scheduler FSM: accept, settle, capture, then hold the response until taken.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ-1);
      cur_id     <= '0;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_id     <= '0;
      rsp_p      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            mul_a      <= gnt_a;
            mul_b      <= gnt_b;
            cur_id     <= gnt_idx;
            last_grant <= gnt_idx;
            cnt        <= 8'(WAIT_CYCLES);
            state      <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            rsp_p  <= mul_p;
            rsp_id <= cur_id;
            state  <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized and directed bench for mul_share_arbiter against a
// transaction-level reference model (job age since accept, round-robin pick).
module tb_mul_share_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int W   = 2;

  logic              slow_clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*32-1:0]   req_a, req_b;
  logic [N-1:0]      req_ready;
  logic [31:0]       mul_a, mul_b;
  logic [63:0]       mul_p;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [63:0]       rsp_p;
  logic              busy;

  mul_share_arbiter #(.N_REQ(N), .ID_W(IDW), .WAIT_CYCLES(W)) dut (
    .slow_clk(slow_clk), .rst(rst), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
  );

  always #5 slow_clk = ~slow_clk;

  // shared multiplier instance
  assign mul_p = 64'($signed(mul_a)) * 64'($signed(mul_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  bit           m_job;
  int           m_age, m_jid, m_last, m_rid;
  logic [63:0]  m_jp, m_rp;
  logic [31:0]  m_ma, m_mb;
  int           acc_id[$];
  int           acc_cyc[$];
  int           cyc = 0;
  int           dut_rsp = 0;
  bit           auto_drop = 1'b0;
  logic [N-1:0] drop_mask = '0;

  function automatic int exp_gnt();
    if (m_job) return -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_job = 0; m_age = 0; m_jid = 0; m_last = N-1; m_rid = 0;
    m_jp = '0; m_rp = '0; m_ma = '0; m_mb = '0;
  endtask

  task automatic compare();
    int g;
    logic [N-1:0] exp_rdy;
    g = exp_gnt();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_job);
    chk("rsp_valid", rsp_valid, (m_job && m_age >= W));
    chk("rsp_id", rsp_id, m_rid);
    chk("rsp_p", rsp_p, m_rp);
    chk("mul_a", mul_a, m_ma);
    chk("mul_b", mul_b, m_mb);
    if (rsp_valid && rsp_ready) dut_rsp++;
  endtask

  task automatic model_update();
    int g;
    if (m_job) begin
      if (m_age >= W) begin
        if (rsp_ready) m_job = 0;
      end else begin
        m_age++;
        if (m_age == W) begin
          m_rp  = m_jp;
          m_rid = m_jid;
        end
      end
    end else begin
      g = exp_gnt();
      if (g >= 0) begin
        m_job  = 1; m_age = 0; m_jid = g; m_last = g;
        m_ma   = req_a[32*g +: 32];
        m_mb   = req_b[32*g +: 32];
        m_jp   = longint'($signed(req_a[32*g +: 32])) * longint'($signed(req_b[32*g +: 32]));
        acc_id.push_back(g);
        acc_cyc.push_back(cyc);
        if (auto_drop) drop_mask[g] = 1'b1;
      end
    end
  endtask

  // one clock: check at negedge, advance model at posedge, drive after edge
  task automatic step();
    if (rst) model_reset();
    @(negedge slow_clk);
    compare();
    @(posedge slow_clk);
    if (!rst) model_update();
    cyc++;
    #1;
    req_valid = req_valid & ~drop_mask;
    drop_mask = '0;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    model_reset();
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_rsp_p", rsp_p, 0);

    // single request from requester 1
    rst = 1'b0; auto_drop = 1'b1;
    set_op(1, 32'd3, -32'sd4);
    req_valid = 4'b0010;
    #1 chk("t1_ready", req_ready, 4'b0010);
    step();
    repeat (W) step();
    chk("t1_vld", rsp_valid, 1);
    chk("t1_id", rsp_id, 1);
    chk("t1_p", rsp_p, 64'hFFFF_FFFF_FFFF_FFF4);
    step();
    chk("t1_busy", busy, 0);

    // round robin with all requesters held valid
    rst = 1'b1; step(); rst = 1'b0;
    acc_id.delete(); acc_cyc.delete(); auto_drop = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 32'(i+1), 32'd10);
    req_valid = '1;
    repeat (5*(W+2)) step();
    req_valid = '0;
    repeat (W+2) step();
    chk("t2_n", acc_id.size(), 5);
    if (acc_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("t2_order", acc_id[k], k % N);
      for (int k = 1; k < 5; k++) chk("t2_interval", acc_cyc[k] - acc_cyc[k-1], W+2);
    end

    // back-pressure on the response channel
    auto_drop = 1'b1; rsp_ready = 1'b0;
    set_op(0, 32'd7, 32'd9);
    req_valid = 4'b0001;
    step();
    repeat (W) step();
    req_valid = 4'b1110;
    n0 = dut_rsp;
    repeat (5) step();
    chk("t3_busy", busy, 1);
    chk("t3_rdy", req_ready, 0);
    chk("t3_p", rsp_p, 64'd63);
    req_valid = '0; rsp_ready = 1'b1;
    repeat (3) step();
    chk("t3_once", dut_rsp - n0, 1);

    // operand extremes and zero
    set_op(2, 32'h8000_0000, 32'h8000_0000);
    req_valid = 4'b0100;
    step();
    repeat (W) step();
    chk("t4_min", rsp_p, 64'h4000_0000_0000_0000);
    chk("t4_mulp", rsp_p, mul_p);
    step();
    set_op(3, 32'd0, $urandom);
    req_valid = 4'b1000;
    step();
    repeat (W) step();
    chk("t4_zero", rsp_p, 64'd0);
    step();

    // reset during CALC discards the job
    set_op(1, 32'd5, 32'd6);
    req_valid = 4'b0010;
    step();
    step();
    rst = 1'b1;
    n0 = dut_rsp;
    #1;
    chk("t5_vld", rsp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_mul_a", mul_a, 0);
    chk("t5_rsp_p", rsp_p, 0);
    repeat (2) step();
    chk("t5_norsp", dut_rsp - n0, 0);
    rst = 1'b0;
    set_op(0, 32'd2, 32'd3);
    set_op(2, 32'd4, 32'd5);
    req_valid = 4'b0101;
    acc_id.delete();
    step();
    req_valid = '0;
    chk("t5_tie", (acc_id.size() > 0) ? acc_id[0] : -1, 0);
    repeat (W+1) step();

    // requester 2 pulses valid only while the block is computing
    set_op(0, 32'd11, 32'd12);
    req_valid = 4'b0001;
    step();
    acc_id.delete();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (W+2) step();
    chk("t6_no2", acc_id.size(), 0);

    // random traffic
    auto_drop = 1'b0;
    repeat (400) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
